elevator_scan_controller: RTL and testbench

//  Parametrised successor of the floor-compare motor logic. Queues multiple floor

---
 rtl/elevator_scan_controller.sv | 150 +++++++++++++++
 tb/tb_elevator_scan_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator controller: pending-request bitmap, per-floor travel timer, door dwell.
// Define ESTOP_EN to add estop_i, which freezes motion and timers while requests keep queuing.
module elevator_scan_controller #(
  parameter int N_FLOORS    = 8,
  parameter int FW          = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  input  logic [FW-1:0]       req_floor_i,
`ifdef ESTOP_EN
  input  logic                estop_i,
`endif
  output logic                req_err_o,
  output logic                en_o,
  output logic                up_down_o,
  output logic [FW-1:0]       cur_floor_o,
  output logic                door_open_o,
  output logic [N_FLOORS-1:0] pending_o,
  output logic                busy_o
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       cur_floor_q, cur_floor_d;
  logic                dir_q, dir_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                req_err_q, en_q, up_down_q, door_open_q, busy_q;

  logic halt;
`ifdef ESTOP_EN
  assign halt = estop_i;
`else
  assign halt = 1'b0;
`endif

  logic [FW-1:0]       step_floor, eval_floor;
  logic [N_FLOORS-1:0] here_mask, above_mask, below_mask, set_mask, clr_mask;
  logic                door_hit, req_in_range, decide;
  logic                any_here, any_ahead, any_behind;

  // Decisions are taken at the floor the cabin will occupy after this edge.
  assign step_floor   = dir_q ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
  assign eval_floor   = (state_q == MOVE) ? step_floor : cur_floor_q;
  assign req_in_range = ({1'b0, req_floor_i} < (FW+1)'(N_FLOORS));
  assign door_hit     = req_valid_i && (state_q == DOOR) && (req_floor_i == cur_floor_q);

  for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor
    assign here_mask[gi]  = (eval_floor == FW'(gi));
    assign above_mask[gi] = (FW'(gi) > eval_floor);
    assign below_mask[gi] = (FW'(gi) < eval_floor);
    assign set_mask[gi]   = req_valid_i && (req_floor_i == FW'(gi)) && !door_hit;
  end

  assign any_here   = |(pending_q & here_mask);
  assign any_ahead  = dir_q ? |(pending_q & above_mask) : |(pending_q & below_mask);
  assign any_behind = dir_q ? |(pending_q & below_mask) : |(pending_q & above_mask);

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_d       = dir_q;
    timer_d     = timer_q;
    clr_mask    = '0;
    decide      = 1'b0;
    if (!halt) begin
      case (state_q)
        IDLE: decide = 1'b1;
        MOVE: begin
          if (timer_q == MOVE_LAST) begin
            cur_floor_d = step_floor;
            decide      = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        DOOR: begin
          if (door_hit)                    timer_d = '0;
          else if (timer_q == DOOR_LAST)   decide  = 1'b1;
          else                             timer_d = timer_q + TW'(1);
        end
        default: state_d = IDLE;
      endcase
      if (decide) begin
        timer_d = '0;
        if (any_here) begin
          state_d  = DOOR;
          clr_mask = here_mask;
        end else if (any_ahead) begin
          state_d = MOVE;
        end else if (any_behind) begin
          state_d = MOVE;
          dir_d   = ~dir_q;
        end else begin
          state_d = IDLE;
        end
      end
      if (cur_floor_d == TOP_FLOOR) dir_d = 1'b0;
      else if (cur_floor_d == '0)   dir_d = 1'b1;
    end
  end

  // A clear on the stop edge beats a simultaneous request for the same floor.
  assign pending_d = (pending_q | set_mask) & ~clr_mask;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_q       <= 1'b1;
      timer_q     <= '0;
      pending_q   <= '0;
      req_err_q   <= 1'b0;
      en_q        <= 1'b0;
      up_down_q   <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      req_err_q   <= req_valid_i && !req_in_range;
      en_q        <= (state_d == MOVE) && !halt;
      up_down_q   <= dir_d;
      door_open_q <= (state_d == DOOR);
      busy_q      <= (state_d != IDLE) || (pending_d != '0);
    end
  end

  assign req_err_o   = req_err_q;
  assign en_o        = en_q;
  assign up_down_o   = up_down_q;
  assign cur_floor_o = cur_floor_q;
  assign door_open_o = door_open_q;
  assign pending_o   = pending_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller (8 floors, 4-cycle moves, 6-cycle door).
// The estop scenario is compiled only when ESTOP_EN is defined.
module tb_elevator_scan_controller;
  localparam int NF = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          req_err, en, up_down, door_open, busy;
  logic [FW-1:0] cur_floor;
  logic [NF-1:0] pending;
`ifdef ESTOP_EN
  logic          estop = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_scan_controller #(
    .N_FLOORS(NF), .FW(FW), .MOVE_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .req_valid_i(req_valid),
    .req_floor_i(req_floor),
`ifdef ESTOP_EN
    .estop_i    (estop),
`endif
    .req_err_o  (req_err),
    .en_o       (en),
    .up_down_o  (up_down),
    .cur_floor_o(cur_floor),
    .door_open_o(door_open),
    .pending_o  (pending),
    .busy_o     (busy)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [FW-1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    step();
    req_valid = 1'b0;
    $display("req floor=%0d -> cur_floor=%0d pending=%b req_err=%0b", f, cur_floor, pending, req_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    send(4'd7);
    n = 0;
    while (cur_floor !== 4'd3 && n < 100) begin step(); n++; end
    checks++; if (cur_floor !== 4'd3 || en !== 1'b1) begin failures++;
      $display("FAIL reset_setup: cur_floor=%0d en=%0b expected floor 3 en 1", cur_floor, en); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({en, up_down, door_open, busy, req_err} !== 5'b0) begin failures++;
      $display("FAIL reset_outputs: en/up/door/busy/err=%b expected 00000", {en, up_down, door_open, busy, req_err}); end
    checks++; if (cur_floor !== 4'd0 || pending !== 8'h00) begin failures++;
      $display("FAIL reset_state: cur_floor=%0d pending=%h expected 0/00", cur_floor, pending); end
    #1 rst = 1'b0;
    step(2);
    $display("test_reset done");
  endtask

  task automatic test_single_request();
    send(4'd5);
    checks++; if (pending !== 8'h20 || en !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL single_capture: pending=%h en=%0b busy=%0b expected 20/0/1", pending, en, busy); end
    step();
    checks++; if (en !== 1'b1 || up_down !== 1'b1) begin failures++;
      $display("FAIL single_start: en=%0b up_down=%0b expected 1/1", en, up_down); end
    step(19);
    checks++; if (cur_floor !== 4'd4 || en !== 1'b1) begin failures++;
      $display("FAIL single_travel: cur_floor=%0d en=%0b expected 4/1", cur_floor, en); end
    step();
    checks++; if (cur_floor !== 4'd5 || door_open !== 1'b1 || en !== 1'b0 || pending !== 8'h00) begin failures++;
      $display("FAIL single_arrive: floor=%0d door=%0b en=%0b pending=%h expected 5/1/0/00", cur_floor, door_open, en, pending); end
    step(5);
    checks++; if (door_open !== 1'b1) begin failures++;
      $display("FAIL single_door_hold: door_open=%0b expected 1", door_open); end
    step();
    checks++; if (door_open !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL single_idle: door_open=%0b busy=%0b expected 0/0", door_open, busy); end
    $display("test_single_request done");
  endtask

  task automatic test_same_floor();
    send(4'd5);
    checks++; if (pending !== 8'h20 || door_open !== 1'b0) begin failures++;
      $display("FAIL same_capture: pending=%h door=%0b expected 20/0", pending, door_open); end
    step();
    checks++; if (door_open !== 1'b1 || pending !== 8'h00 || en !== 1'b0) begin failures++;
      $display("FAIL same_open: door=%0b pending=%h en=%0b expected 1/00/0", door_open, pending, en); end
    step(6);
    checks++; if (door_open !== 1'b0) begin failures++;
      $display("FAIL same_close: door_open=%0b expected 0", door_open); end
    $display("test_same_floor done");
  endtask

  task automatic test_scan_order();
    int n;
    int nstops;
    logic [FW-1:0] stops [3];
    logic prev_door;
    do_reset();
    send(4'd6);
    n = 0;
    while (cur_floor !== 4'd2 && n < 50) begin step(); n++; end
    checks++; if (cur_floor !== 4'd2) begin failures++;
      $display("FAIL scan_reach2: cur_floor=%0d expected 2", cur_floor); end
    send(4'd1);
    send(4'd4);
    nstops = 0;
    prev_door = door_open;
    for (int i = 0; i < 3; i++) stops[i] = '1;
    for (int i = 0; i < 150; i++) begin
      step();
      if (door_open === 1'b1 && prev_door !== 1'b1) begin
        if (nstops < 3) stops[nstops] = cur_floor;
        nstops++;
      end
      prev_door = door_open;
    end
    checks++; if (nstops != 3) begin failures++;
      $display("FAIL scan_count: stops=%0d expected 3", nstops); end
    checks++; if (stops[0] !== 4'd4 || stops[1] !== 4'd6 || stops[2] !== 4'd1) begin failures++;
      $display("FAIL scan_order: stops=%0d,%0d,%0d expected 4,6,1", stops[0], stops[1], stops[2]); end
    checks++; if (pending !== 8'h00 || busy !== 1'b0 || cur_floor !== 4'd1) begin failures++;
      $display("FAIL scan_final: pending=%h busy=%0b floor=%0d expected 00/0/1", pending, busy, cur_floor); end
    $display("test_scan_order done");
  endtask

  task automatic test_door_restart();
    int n;
    do_reset();
    send(4'd3);
    n = 0;
    while (door_open !== 1'b1 && n < 60) begin step(); n++; end
    checks++; if (door_open !== 1'b1 || cur_floor !== 4'd3) begin failures++;
      $display("FAIL restart_arrive: door=%0b floor=%0d expected 1/3", door_open, cur_floor); end
    step(3);
    send(4'd3);
    checks++; if (door_open !== 1'b1 || pending !== 8'h00) begin failures++;
      $display("FAIL restart_req: door=%0b pending=%h expected 1/00", door_open, pending); end
    step(2);
    checks++; if (door_open !== 1'b1) begin failures++;
      $display("FAIL restart_extend: door_open=%0b expected 1", door_open); end
    step(3);
    checks++; if (door_open !== 1'b1 || pending !== 8'h00) begin failures++;
      $display("FAIL restart_last: door=%0b pending=%h expected 1/00", door_open, pending); end
    step();
    checks++; if (door_open !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL restart_close: door=%0b busy=%0b expected 0/0", door_open, busy); end
    $display("test_door_restart done");
  endtask

  task automatic test_out_of_range();
    send(4'd9);
    checks++; if (req_err !== 1'b1 || pending !== 8'h00) begin failures++;
      $display("FAIL oor9_pulse: req_err=%0b pending=%h expected 1/00", req_err, pending); end
    step();
    checks++; if (req_err !== 1'b0) begin failures++;
      $display("FAIL oor9_clear: req_err=%0b expected 0", req_err); end
    send(4'd15);
    checks++; if (req_err !== 1'b1 || pending !== 8'h00) begin failures++;
      $display("FAIL oor15_pulse: req_err=%0b pending=%h expected 1/00", req_err, pending); end
    step();
    checks++; if (req_err !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL oor15_clear: req_err=%0b busy=%0b expected 0/0", req_err, busy); end
    $display("test_out_of_range done");
  endtask

`ifdef ESTOP_EN
  task automatic test_estop();
    do_reset();
    send(4'd5);
    step(3);
    estop = 1'b1;
    step();
    checks++; if (en !== 1'b0 || cur_floor !== 4'd0) begin failures++;
      $display("FAIL estop_stop: en=%0b floor=%0d expected 0/0", en, cur_floor); end
    step(9);
    checks++; if (en !== 1'b0 || cur_floor !== 4'd0 || pending !== 8'h20) begin failures++;
      $display("FAIL estop_hold: en=%0b floor=%0d pending=%h expected 0/0/20", en, cur_floor, pending); end
    estop = 1'b0;
    step();
    checks++; if (en !== 1'b1 || cur_floor !== 4'd0) begin failures++;
      $display("FAIL estop_resume: en=%0b floor=%0d expected 1/0", en, cur_floor); end
    step();
    checks++; if (cur_floor !== 4'd1) begin failures++;
      $display("FAIL estop_advance: floor=%0d expected 1", cur_floor); end
    $display("test_estop done");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    test_reset();
    test_single_request();
    test_same_floor();
    test_scan_order();
    test_door_restart();
    test_out_of_range();
`ifdef ESTOP_EN
    test_estop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
